grid_checker: RTL and testbench

- Downstream consumer of the `grid` generator.
- After `grid` raises `done`, `grid_checker` scans every cell through a read port in row-major order.
- It verifies the Sudoku constraints: each value appears exactly once per row, per column and per block, and every cell holds exactly one value.
- It reports a pass/fail verdict and the coordinates of the first violation. Used in system benches and as an on-chip self-check.

---
 rtl/grid_checker.sv | 141 ++++++++++++++
 tb/tb_grid_checker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/grid_checker.sv
// Sudoku grid checker: scans a LENGTH x LENGTH one-hot grid through a synchronous read port
// and reports pass/fail plus the coordinates of the first violating cell.
module grid_checker #(
    parameter int unsigned ORDER = 3,
    localparam int unsigned LENGTH = ORDER * ORDER,
    localparam int unsigned CW = $clog2(LENGTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [CW-1:0]     rd_row,
    output logic [CW-1:0]     rd_col,
    input  logic [LENGTH-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic [CW-1:0]     err_row,
    output logic [CW-1:0]     err_col
);

    localparam int unsigned BW = (ORDER > 1) ? $clog2(ORDER) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]     row_q, col_q;
    logic [CW-1:0]     tag_row_q, tag_col_q;
    logic              vld_q;
    logic              fail_q;
    logic [CW-1:0]     err_row_q, err_col_q;
    logic [LENGTH-1:0] rowmask_q;
    logic [LENGTH-1:0] colmask_q [LENGTH];
    logic [LENGTH-1:0] blkmask_q [ORDER];

    logic              start_acc;
    logic              last_addr;
    logic              band_clear;
    logic              onehot;
    logic              violation;
    logic [BW-1:0]     blk_idx;
    logic [LENGTH-1:0] row_base;
    logic [LENGTH-1:0] blk_base [ORDER];

    assign start_acc = start && ((state_q == StIdle) || (state_q == StFinish));
    assign last_addr = (row_q == CW'(LENGTH - 1)) && (col_q == CW'(LENGTH - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StIssue;
            StIssue:  if (last_addr) state_d = StDrain;
            StDrain:  state_d = StFinish;
            StFinish: if (start) state_d = StIssue;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Masks are cleared at row/band boundaries before the boundary cell is checked.
    always_comb begin
        band_clear = (tag_col_q == '0) && ((tag_row_q % CW'(ORDER)) == '0);
        blk_idx    = BW'(tag_col_q / CW'(ORDER));
        row_base   = (tag_col_q == '0) ? '0 : rowmask_q;
        for (int b = 0; b < ORDER; b++) begin
            blk_base[b] = band_clear ? '0 : blkmask_q[b];
        end
        onehot    = (rd_data != '0) && ((rd_data & (rd_data - LENGTH'(1))) == '0);
        violation = !onehot
                    || ((rd_data & row_base) != '0)
                    || ((rd_data & colmask_q[tag_col_q]) != '0)
                    || ((rd_data & blk_base[blk_idx]) != '0);
    end

    always_ff @(posedge clock) begin
        if (reset || start_acc) begin
            row_q     <= '0;
            col_q     <= '0;
            tag_row_q <= '0;
            tag_col_q <= '0;
            vld_q     <= 1'b0;
            fail_q    <= 1'b0;
            err_row_q <= '0;
            err_col_q <= '0;
            rowmask_q <= '0;
            for (int i = 0; i < LENGTH; i++) begin
                colmask_q[i] <= '0;
            end
            for (int b = 0; b < ORDER; b++) begin
                blkmask_q[b] <= '0;
            end
        end else begin
            // The tag follows the request so returning data knows its cell.
            vld_q     <= (state_q == StIssue);
            tag_row_q <= row_q;
            tag_col_q <= col_q;

            if (state_q == StIssue) begin
                if (col_q == CW'(LENGTH - 1)) begin
                    col_q <= '0;
                    if (!last_addr) begin
                        row_q <= row_q + CW'(1);
                    end
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end

            if (vld_q) begin
                rowmask_q            <= row_base | rd_data;
                colmask_q[tag_col_q] <= colmask_q[tag_col_q] | rd_data;
                for (int b = 0; b < ORDER; b++) begin
                    blkmask_q[b] <= (BW'(b) == blk_idx) ? (blk_base[b] | rd_data) : blk_base[b];
                end
                if (violation && !fail_q) begin
                    fail_q    <= 1'b1;
                    err_row_q <= tag_row_q;
                    err_col_q <= tag_col_q;
                end
            end
        end
    end

    assign rd_en   = (state_q == StIssue);
    assign rd_row  = row_q;
    assign rd_col  = col_q;
    assign busy    = (state_q == StIssue) || (state_q == StDrain);
    assign done    = (state_q == StFinish);
    assign success = done && !fail_q;
    assign err_row = err_row_q;
    assign err_col = err_col_q;

endmodule

// File: tb/tb_grid_checker.sv
// Directed bench for grid_checker (ORDER=3) with a registered one-cycle grid read model.
module tb_grid_checker;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       rd_en;
    logic [3:0] rd_row;
    logic [3:0] rd_col;
    logic [8:0] rd_data = '0;
    logic       busy;
    logic       done;
    logic       success;
    logic [3:0] err_row;
    logic [3:0] err_col;

    logic [8:0] gm [9][9];
    int n_cmp = 0;
    int n_bad = 0;

    grid_checker #(.ORDER(3)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .rd_en   (rd_en),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .success (success),
        .err_row (err_row),
        .err_col (err_col)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rd_data <= rd_en ? gm[rd_row][rd_col] : '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_valid();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                gm[r][c] = 9'(1) << ((3 * r + r / 3 + c) % 9);
    endtask

    task automatic fill_latin();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                gm[r][c] = 9'(1) << ((r + c) % 9);
    endtask

    task automatic check_idle_zero(input string name);
        check({name, ":rd_en"}, rd_en, 0);
        check({name, ":rd_row"}, rd_row, 0);
        check({name, ":rd_col"}, rd_col, 0);
        check({name, ":busy"}, busy, 0);
        check({name, ":done"}, done, 0);
        check({name, ":success"}, success, 0);
        check({name, ":err_row"}, err_row, 0);
        check({name, ":err_col"}, err_col, 0);
    endtask

    // Pulses start at E0, walks to E82 and checks the verdict.
    task automatic run_scan(input string name, input bit noise, input bit exp_ok,
                            input int er, input int ec);
        int en_cnt;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check({name, ":first_rd_en"}, rd_en, 1);
        check({name, ":first_row"}, rd_row, 0);
        check({name, ":first_col"}, rd_col, 0);
        check({name, ":first_busy"}, busy, 1);
        check({name, ":first_done"}, done, 0);
        en_cnt = int'(rd_en);
        for (int k = 1; k <= 81; k++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            en_cnt += int'(rd_en);
            if (noise && (k % 17 == 5)) start = 1'b1;
        end
        start = 1'b0;
        check({name, ":done_e81"}, done, 0);
        check({name, ":busy_e81"}, busy, 1);
        @(posedge clock);
        #1;
        check({name, ":rd_en_cycles"}, en_cnt, 81);
        check({name, ":done_e82"}, done, 1);
        check({name, ":busy_e82"}, busy, 0);
        check({name, ":rd_en_e82"}, rd_en, 0);
        check({name, ":success"}, success, exp_ok);
        check({name, ":err_row"}, err_row, er);
        check({name, ":err_col"}, err_col, ec);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill_valid();
        repeat (2) @(posedge clock);
        #1;
        check_idle_zero("reset");
        reset = 1'b0;

        run_scan("valid", 1'b0, 1'b1, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        check("valid:hold_done", done, 1);
        check("valid:hold_success", success, 1);

        fill_valid();
        gm[2][5] = gm[2][0];
        run_scan("dup", 1'b0, 1'b0, 2, 5);

        fill_latin();
        run_scan("latin", 1'b0, 1'b0, 1, 0);

        fill_valid();
        gm[4][4] = '0;
        run_scan("zero", 1'b0, 1'b0, 4, 4);

        fill_valid();
        gm[7][3] = gm[7][3] | {gm[7][3][7:0], gm[7][3][8]};
        run_scan("twobit", 1'b0, 1'b0, 7, 3);

        // Reset in the middle of a scan, with start raised on the same edge.
        fill_valid();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check("midscan:busy_before", busy, 1);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        check_idle_zero("midreset");
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("midreset:stay_idle", busy, 0);
        run_scan("after_rst", 1'b0, 1'b1, 0, 0);

        run_scan("noisy", 1'b1, 1'b1, 0, 0);
        run_scan("restart", 1'b0, 1'b1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
